// File: rtl/fetch_unit.sv
// Decoupled instruction fetch stage.
// Issues sequential fetch requests over a valid/ready channel and accepts
// in-order responses into a small prefetch queue that feeds decode.
// A redirect flushes the queue and discards every response still in flight.
// Queue entries plus in-flight requests never exceed DEPTH, so a response
// always finds a free queue slot.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_INC   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WIDTH-1:0]         imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [WIDTH-1:0]         imem_resp_data,
    input  logic                     redirect_valid,
    input  logic [WIDTH-1:0]         redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [WIDTH-1:0]         instr_data,
    output logic [WIDTH-1:0]         instr_pc,
    output logic [WIDTH-1:0]         instr_pc_next,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     err_unexpected_response
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam int unsigned      CW      = AW + 1;
    localparam logic [WIDTH-1:0] INC     = WIDTH'(PC_INC);
    localparam logic [CW:0]      DEPTH_C = (CW + 1)'(DEPTH);

    // Control state
    logic             r_run;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_resp_pc;
    logic [CW-1:0]    r_outstanding;
    logic [CW-1:0]    r_drop;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_err;

    // Queue storage (data only, never reset)
    logic [WIDTH-1:0] r_q_data [DEPTH];
    logic [WIDTH-1:0] r_q_pc   [DEPTH];

    logic [CW:0]      w_credit;
    logic             w_req_fire;
    logic             w_resp_ok;
    logic             w_resp_drop;
    logic             w_push;
    logic             w_pop;

    // Credit covers both queued entries and requests whose responses are pending.
    assign w_credit       = {1'b0, r_count} + {1'b0, r_outstanding};

    // r_run holds the request channel idle until the first edge after reset.
    assign imem_req_valid = r_run && !redirect_valid && (w_credit < DEPTH_C);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response only counts against requests accepted in earlier cycles.
    assign w_resp_ok      = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_drop    = w_resp_ok && (r_drop != '0);
    assign w_push         = w_resp_ok && (r_drop == '0) && !redirect_valid;
    assign w_pop          = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid             = (r_count != '0);
    assign instr_data              = r_q_data[r_rd_ptr];
    assign instr_pc                = r_q_pc[r_rd_ptr];
    assign instr_pc_next           = instr_pc + INC;
    assign queue_count             = r_count;
    assign err_unexpected_response = r_err;

    // Fetch address, response address and outstanding/drop bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_err         <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
            if (imem_resp_valid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                // Everything still in flight after this cycle belongs to the old path.
                r_drop     <= r_outstanding - CW'(w_resp_ok);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + INC;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + INC;
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Registered queue write: an accepted response becomes visible next cycle.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= imem_resp_data;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_next;
    logic [2:0]  queue_count;
    logic        err_unexpected_response;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model controls
    logic [31:0] pend[$];
    int          nacc = 0;
    bit          hold = 0;
    bit          inj = 0;
    bit          cur_bad = 0;

    fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .imem_req_valid          (imem_req_valid),
        .imem_req_ready          (imem_req_ready),
        .imem_req_addr           (imem_req_addr),
        .imem_resp_valid         (imem_resp_valid),
        .imem_resp_data          (imem_resp_data),
        .redirect_valid          (redirect_valid),
        .redirect_pc             (redirect_pc),
        .instr_valid             (instr_valid),
        .instr_ready             (instr_ready),
        .instr_data              (instr_data),
        .instr_pc                (instr_pc),
        .instr_pc_next           (instr_pc_next),
        .queue_count             (queue_count),
        .err_unexpected_response (err_unexpected_response)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // In-order memory: answers one cycle after acceptance unless held.
    always @(posedge clock) begin
        if (!reset) begin
            pend.delete();
            nacc = 0;
        end else begin
            if (imem_resp_valid && !cur_bad && pend.size() > 0) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back(imem_req_addr);
                nacc++;
            end
        end
        #1;
        cur_bad = inj && reset;
        inj = 0;
        if (cur_bad) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else if (reset && !hold && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mdat(pend[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic rst_on();
        reset = 1'b0;
        redirect_valid = 1'b0;
        inj = 0;
        @(posedge clock);
        #2;
    endtask

    task automatic rst_off();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        // ---- T1: reset state and sequential streaming
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        hold           = 0;
        rst_on();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_err", 32'(err_unexpected_response), 32'd0);
        rst_off();
        chk("t1_first_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_addr", imem_req_addr, 32'h0);
        tick();
        chk("t1_addr1", imem_req_addr, 32'h4);
        chk("t1_not_yet", 32'(instr_valid), 32'd0);
        tick();
        chk("t1_valid0", 32'(instr_valid), 32'd1);
        chk("t1_pc0", instr_pc, 32'h0);
        chk("t1_data0", instr_data, mdat(32'h0));
        chk("t1_pcn0", instr_pc_next, 32'h4);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t1_valid", 32'(instr_valid), 32'd1);
            chk("t1_pc", instr_pc, 32'(4 * i));
            chk("t1_pcn", instr_pc_next, 32'(4 * i + 4));
            chk("t1_data", instr_data, mdat(32'(4 * i)));
            chk("t1_count", 32'(queue_count), 32'd1);
        end

        // ---- T2: backpressure, credit limit, unexpected response
        rst_on();
        instr_ready = 1'b0;
        rst_off();
        repeat (8) tick();
        chk("t2_nacc", 32'(nacc), 32'd4);
        chk("t2_req_off", 32'(imem_req_valid), 32'd0);
        chk("t2_full", 32'(queue_count), 32'd4);
        chk("t2_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_pop_count", 32'(queue_count), 32'd3);
        chk("t2_pop_head", instr_pc, 32'h4);
        chk("t2_resume", 32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr", imem_req_addr, 32'h10);
        tick();
        chk("t2_nacc5", 32'(nacc), 32'd5);
        chk("t2_req_off2", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t2_refill", 32'(queue_count), 32'd4);
        inj = 1;
        tick();
        chk("t2_err_pre", 32'(err_unexpected_response), 32'd0);
        tick();
        chk("t2_err_set", 32'(err_unexpected_response), 32'd1);
        chk("t2_err_count", 32'(queue_count), 32'd4);
        chk("t2_err_head", instr_pc, 32'h4);
        instr_ready = 1'b1;
        repeat (10) tick();
        chk("t2_err_sticky", 32'(err_unexpected_response), 32'd1);
        chk("t2_flow", 32'(instr_valid), 32'd1);
        rst_on();
        chk("t2_err_clear", 32'(err_unexpected_response), 32'd0);

        // ---- T3: redirect with three requests outstanding
        hold = 1;
        instr_ready = 1'b1;
        rst_off();
        repeat (3) tick();
        chk("t3_addr12", imem_req_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        hold = 0;
        chk("t3_flushed", 32'(queue_count), 32'd0);
        chk("t3_new_addr", imem_req_addr, 32'h100);
        wait_valid("t3_wait");
        chk("t3_pc", instr_pc, 32'h100);
        chk("t3_data", instr_data, mdat(32'h100));
        tick();
        chk("t3_pc2", instr_pc, 32'h104);

        // ---- T4: redirect coinciding with a response and a pop
        rst_on();
        rst_off();
        repeat (5) tick();
        chk("t4_resp_pre", 32'(imem_resp_valid), 32'd1);
        chk("t4_valid_pre", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_empty", 32'(queue_count), 32'd0);
        chk("t4_ivalid", 32'(instr_valid), 32'd0);
        wait_valid("t4_wait");
        chk("t4_pc", instr_pc, 32'h200);
        chk("t4_data", instr_data, mdat(32'h200));
        tick();
        chk("t4_pc2", instr_pc, 32'h204);

        // ---- T5: address wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr_f8", imem_req_addr, 32'hFFFF_FFF8);
        tick();
        chk("t5_addr_fc", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("t5_addr_wrap", imem_req_addr, 32'h0);
        chk("t5_pc_f8", instr_pc, 32'hFFFF_FFF8);
        tick();
        chk("t5_pc_fc", instr_pc, 32'hFFFF_FFFC);
        chk("t5_pcn_wrap", instr_pc_next, 32'h0);
        tick();
        chk("t5_pc_0", instr_pc, 32'h0);
        chk("t5_pcn_4", instr_pc_next, 32'h4);
        chk("t5_data_0", instr_data, mdat(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Decoupled instruction fetch stage; next generation of the single-cycle PC/instruction-memory path.
- Issues PC-sequential requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions in a DEPTH-entry prefetch queue for the decode stage.
- Supports branch/jump redirect with flush and discard of in-flight responses.

Parameters:
WIDTH, 32, address and instruction width in bits
DEPTH, 4, prefetch queue entries; power of 2, ≥2; also the max outstanding-plus-queued credit
RESET_PC, 0, fetch address after reset
PC_INC, 4, sequential address increment

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
imem_req_valid  output  1  request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  WIDTH  request address
imem_resp_valid  input  1  response data valid; in request order; earliest one cycle after acceptance
imem_resp_data  input  WIDTH  fetched instruction
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  WIDTH  new fetch address
instr_valid  output  1  queue head valid
instr_ready  input  1  decode consumes head
instr_data  output  WIDTH  head instruction
instr_pc  output  WIDTH  address of head instruction
instr_pc_next  output  WIDTH  instr_pc + PC_INC, for link writeback
queue_count  output  clog2(DEPTH)+1  current queue occupancy
err_unexpected_response  output  1  sticky; response seen with zero outstanding

Behaviour:
- Reset (reset=0, asynchronous) drives the following state and outputs:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue empty; outstanding=0; drop=0.
  - imem_req_valid=0, instr_valid=0, queue_count=0, err_unexpected_response=0.
- Reset deassertion: imem_req_valid may rise on the first clock edge after deassertion.
- Request issue:
  - imem_req_valid = !redirect_valid && (queue_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += PC_INC (modulo 2^WIDTH) and outstanding++.
  - Valid may drop while ready is low only on redirect. The address is held stable otherwise.
- Response, when drop>0:
  - drop--, outstanding--; data discarded.
- Response, when drop=0 and outstanding>0:
  - Push {imem_resp_data, resp_pc}; resp_pc += PC_INC; outstanding--.
- Response, when outstanding=0 (counting a request accepted in the same cycle as zero):
  - Ignored; err_unexpected_response set until reset.
- Credit invariant: queue_count + outstanding ≤ DEPTH. A push therefore never hits a full queue.
- Output:
  - instr_valid = (queue_count≠0); instr_data and instr_pc come from the head entry.
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle leave queue_count unchanged.
- Latency: accepted response to instr_valid is 1 cycle (registered queue write). No combinational path from imem_resp to instr_*.
- Redirect (redirect_valid=1), in one cycle:
  - Queue flushed (queue_count←0); pop ignored.
  - fetch_pc←redirect_pc, resp_pc←redirect_pc.
  - drop←outstanding − (1 if response this cycle).
  - Response this cycle discarded; no request issued this cycle.
  - outstanding decremented by any same-cycle response.
- Back-to-back redirects: each recomputes drop from current outstanding; the last redirect_pc wins.
- Wrap-around: fetch_pc, resp_pc and instr_pc_next all wrap modulo 2^WIDTH.
- Reset mid-operation: all state is cleared immediately. Responses arriving later with outstanding=0 flag the error; the memory must be reset together with this block.

Test Plan:
- Reset release, imem ready=1, fixed 1-cycle response, instr_ready=1 → addresses 0,4,8,… issued; instr_pc sequence 0,4,8,…; instr_pc_next = instr_pc+4; steady throughput 1 instr/cycle.
- instr_ready=0, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0 and queue_count=4; on instr_ready=1, issue resumes once per pop.
- Redirect to 0x100 with 3 requests outstanding → next 3 responses dropped; first delivered instr_pc=0x100; queue_count=0 the cycle after redirect.
- Redirect in the same cycle as a response and a pop → response discarded, drop=outstanding−1, queue empty; next delivered instr_pc=redirect_pc.
- fetch_pc=0xFFFFFFFC sequential fetch → next address 0x00000000; instr_pc_next of the last word = 0.
- Response with no outstanding request → err_unexpected_response=1, queue unchanged; stays 1 until reset=0.
